ysyx_bus_arb: RTL

Two-master, one-slave memory-bus arbiter and sequencer between the IFU fetch port and the EXU load/store port. It grants the single downstream memory bus to one requester at a time, latches the granted request, and drives it until the slave accepts it. It then waits for the response and returns it to the owner as a one-cycle pulse. It also does byte-lane steering for stores, read-data alignment and extension for loads, and drops fetch responses killed by a pipeline flush.

---
 rtl/ysyx_bus_arb.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_bus_arb.sv
// Two-master (IFU fetch, LSU load/store) to one-slave memory bus arbiter and sequencer.
// Grants and latches one request at a time, steers store lanes, and aligns/extends load data.
//
// state | meaning
// IDLE  | no transaction; arbitrate between IFU and LSU
// REQ   | bus_valid high, latched request held until bus_ready
// WAIT  | request accepted, waiting for the matching response
// DONE  | one-cycle response pulse to the owner
module ysyx_bus_arb #(
    parameter int BIT_W        = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ifu_avalid,
    input  logic [BIT_W-1:0] ifu_addr,
    output logic             ifu_rvalid,
    output logic [31:0]      ifu_rdata,
    input  logic             flush,
    input  logic             lsu_avalid,
    input  logic             lsu_ren,
    input  logic             lsu_wen,
    input  logic [BIT_W-1:0] lsu_addr,
    input  logic [BIT_W-1:0] lsu_wdata,
    input  logic [1:0]       lsu_size,
    input  logic             lsu_sext,
    output logic             lsu_rvalid,
    output logic             lsu_wready,
    output logic [BIT_W-1:0] lsu_rdata,
    output logic             bus_valid,
    output logic             bus_we,
    output logic [BIT_W-1:0] bus_addr,
    output logic [31:0]      bus_wdata,
    output logic [3:0]       bus_wstrb,
    input  logic             bus_ready,
    input  logic             bus_rvalid,
    input  logic             bus_bvalid,
    input  logic [31:0]      bus_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic             owner_lsu_q, owner_lsu_d;
    logic [SW-1:0]    streak_q, streak_d;
    logic             kill_q, kill_d;
    logic             we_q, we_d;
    logic [BIT_W-1:0] addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [1:0]       size_q, size_d;
    logic             sext_q, sext_d;
    logic             ifu_rvalid_q, ifu_rvalid_d;
    logic             lsu_rvalid_q, lsu_rvalid_d;
    logic             lsu_wready_q, lsu_wready_d;
    logic [31:0]      ifu_rdata_q, ifu_rdata_d;
    logic [BIT_W-1:0] lsu_rdata_q, lsu_rdata_d;

    logic        resp;
    logic        lsu_req;
    logic        ifu_win;
    logic        finish;
    logic [3:0]  strb_base;
    logic [3:0]  st_strb;
    logic [31:0] st_wdata;
    logic [31:0] ld_shift;
    logic [31:0] ld_val;

    always_comb begin
        state_d      = state_q;
        owner_lsu_d  = owner_lsu_q;
        streak_d     = streak_q;
        kill_d       = kill_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        size_d       = size_q;
        sext_d       = sext_q;
        ifu_rvalid_d = 1'b0;
        lsu_rvalid_d = 1'b0;
        lsu_wready_d = 1'b0;
        ifu_rdata_d  = ifu_rdata_q;
        lsu_rdata_d  = lsu_rdata_q;
        finish       = 1'b0;

        resp    = we_q ? bus_bvalid : bus_rvalid;
        lsu_req = lsu_avalid && (lsu_ren || lsu_wen);
        ifu_win = ifu_avalid && !flush && (!lsu_req || streak_q == SW'(STARVE_LIMIT));

        case (lsu_size)
            2'd0:    strb_base = 4'b0001;
            2'd1:    strb_base = 4'b0011;
            default: strb_base = 4'b1111;
        endcase
        st_strb  = strb_base << lsu_addr[1:0];
        st_wdata = 32'(lsu_wdata) << {lsu_addr[1:0], 3'b000};

        // the low address bits of the latched request double as the load lane offset
        ld_shift = bus_rdata >> {addr_q[1:0], 3'b000};
        case (size_q)
            2'd0:    ld_val = sext_q ? {{24{ld_shift[7]}}, ld_shift[7:0]}
                                     : {24'b0, ld_shift[7:0]};
            2'd1:    ld_val = sext_q ? {{16{ld_shift[15]}}, ld_shift[15:0]}
                                     : {16'b0, ld_shift[15:0]};
            default: ld_val = ld_shift;
        endcase

        case (state_q)
            S_IDLE: begin
                if (ifu_win) begin
                    state_d     = S_REQ;
                    owner_lsu_d = 1'b0;
                    streak_d    = '0;
                    we_d        = 1'b0;
                    addr_d      = ifu_addr;
                    wdata_d     = '0;
                    wstrb_d     = '0;
                    size_d      = 2'd2;
                    sext_d      = 1'b0;
                end else if (lsu_req) begin
                    state_d     = S_REQ;
                    owner_lsu_d = 1'b1;
                    if (ifu_avalid && streak_q != SW'(STARVE_LIMIT))
                        streak_d = streak_q + SW'(1);
                    we_d        = lsu_wen;
                    addr_d      = lsu_addr;
                    wdata_d     = lsu_wen ? st_wdata : '0;
                    wstrb_d     = lsu_wen ? st_strb : '0;
                    size_d      = lsu_size;
                    sext_d      = lsu_sext;
                end
            end
            S_REQ: begin
                if (!owner_lsu_q && flush) kill_d = 1'b1;
                if (bus_ready) begin
                    if (resp) finish = 1'b1;
                    else      state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!owner_lsu_q && flush) kill_d = 1'b1;
                if (resp) finish = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                kill_d  = 1'b0;
            end
        endcase

        if (finish) begin
            state_d = S_DONE;
            if (owner_lsu_q) begin
                if (we_q) begin
                    lsu_wready_d = 1'b1;
                end else begin
                    lsu_rvalid_d = 1'b1;
                    lsu_rdata_d  = BIT_W'(ld_val);
                end
            end else if (!(kill_q || flush)) begin
                ifu_rvalid_d = 1'b1;
                ifu_rdata_d  = bus_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            owner_lsu_q  <= 1'b0;
            streak_q     <= '0;
            kill_q       <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            size_q       <= '0;
            sext_q       <= 1'b0;
            ifu_rvalid_q <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            lsu_wready_q <= 1'b0;
            ifu_rdata_q  <= '0;
            lsu_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_lsu_q  <= owner_lsu_d;
            streak_q     <= streak_d;
            kill_q       <= kill_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            size_q       <= size_d;
            sext_q       <= sext_d;
            ifu_rvalid_q <= ifu_rvalid_d;
            lsu_rvalid_q <= lsu_rvalid_d;
            lsu_wready_q <= lsu_wready_d;
            ifu_rdata_q  <= ifu_rdata_d;
            lsu_rdata_q  <= lsu_rdata_d;
        end
    end

    assign bus_valid  = (state_q == S_REQ);
    assign bus_we     = we_q;
    assign bus_addr   = {addr_q[BIT_W-1:2], 2'b00};
    assign bus_wdata  = wdata_q;
    assign bus_wstrb  = wstrb_q;
    assign ifu_rvalid = ifu_rvalid_q;
    assign ifu_rdata  = ifu_rdata_q;
    assign lsu_rvalid = lsu_rvalid_q;
    assign lsu_wready = lsu_wready_q;
    assign lsu_rdata  = lsu_rdata_q;

endmodule
